// File: rtl/de2_io_pkg.sv
// ---------------------------------------------------------------------------
// de2_io_pkg
// Shared definitions for the DE2 input conditioner:
//   NUM_KEYS_DEF / NUM_SW_DEF : default pushbutton and slide-switch counts
//   rst_state_t               : reset conditioner states (HOLD, RUN)
//   clog2()                   : constant ceil(log2(n)), never less than 1
// ---------------------------------------------------------------------------
package de2_io_pkg;

    localparam int unsigned NUM_KEYS_DEF = 4;
    localparam int unsigned NUM_SW_DEF   = 18;

    typedef enum logic [0:0] {
        HOLD = 1'b0,
        RUN  = 1'b1
    } rst_state_t;

    // Minimum of 1 so that a counter sized from it always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// Two-flop synchroniser followed by a tick-based debounce counter for one
// board input. The debounced value follows the synchronised input only after
// it has disagreed on STABLE_TICKS consecutive sample ticks.
//
// Optional build macro: DE2_KEY_PRESS_PULSE_EN adds o_fall.
//
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous active-low reset
//   i_tick     one-cycle sample strobe from the prescaler
//   i_raw      raw (asynchronous) input pin
//   o_db       debounced value (resets to RESET_VAL)
//   o_fall     (macro only) registered pulse in the cycle o_db first reads 0
// ---------------------------------------------------------------------------
module debounce_cell import de2_io_pkg::*; #(
    parameter int unsigned STABLE_TICKS = 8,
    parameter logic        RESET_VAL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_db
`ifdef DE2_KEY_PRESS_PULSE_EN
    ,
    output logic o_fall
`endif
);

    localparam int unsigned     CntW    = clog2(STABLE_TICKS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic [CntW-1:0] r_cnt;
    logic            w_db_d;
    logic [CntW-1:0] w_cnt_d;

    // Any cycle of agreement clears the count, so only an unbroken run of
    // disagreeing ticks can commit a new value.
    always_comb begin
        w_db_d  = r_db;
        w_cnt_d = r_cnt;
        if (r_sync2 == r_db) begin
            w_cnt_d = '0;
        end else if (i_tick) begin
            if (r_cnt == CntLast) begin
                w_db_d  = r_sync2;
                w_cnt_d = '0;
            end else begin
                w_cnt_d = r_cnt + CntW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_db    <= RESET_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_db    <= w_db_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign o_db = r_db;

`ifdef DE2_KEY_PRESS_PULSE_EN
    logic r_fall;

    // Registered alongside r_db so the pulse lines up with the 1->0 edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_fall <= 1'b0;
        end else begin
            r_fall <= r_db & ~w_db_d;
        end
    end

    assign o_fall = r_fall;
`endif

endmodule

// File: rtl/de2_input_conditioner.sv
// ---------------------------------------------------------------------------
// de2_input_conditioner
// Conditions the DE2 pushbuttons and slide switches for the Nios II PIOs and
// derives a stretched system reset from debounced KEY[0].
//
// Optional build macro: DE2_KEY_PRESS_PULSE_EN adds o_key_press.
//
// Ports:
//   i_clk          PLL system clock
//   i_reset_n      synchronous active-low reset (power-on / PLL locked)
//   i_key_raw      raw pushbuttons, active-low (0 = pressed)
//   i_sw_raw       raw slide switches
//   o_key_db       debounced pushbuttons, active-low
//   o_sw_db        debounced slide switches
//   o_sys_reset_n  registered conditioned reset for nios_system
//   o_tick         one-cycle debounce sample strobe
//   o_key_press    (macro only) one-cycle pulse per key on debounced press
// ---------------------------------------------------------------------------
module de2_input_conditioner import de2_io_pkg::*; #(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned STABLE_TICKS   = 8,
    parameter int unsigned RST_HOLD_TICKS = 16,
    parameter int unsigned NUM_KEYS       = NUM_KEYS_DEF,
    parameter int unsigned NUM_SW         = NUM_SW_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NUM_KEYS-1:0] i_key_raw,
    input  logic [NUM_SW-1:0]   i_sw_raw,
    output logic [NUM_KEYS-1:0] o_key_db,
    output logic [NUM_SW-1:0]   o_sw_db,
    output logic                o_sys_reset_n,
    output logic                o_tick
`ifdef DE2_KEY_PRESS_PULSE_EN
    ,
    output logic [NUM_KEYS-1:0] o_key_press
`endif
);

    localparam int unsigned      DivW     = clog2(TICK_DIV);
    localparam logic [DivW-1:0]  DivLast  = DivW'(TICK_DIV - 1);
    localparam int unsigned      HoldW    = clog2(RST_HOLD_TICKS + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD_TICKS - 1);

    // ---------------- Prescaler ----------------
    logic [DivW-1:0] r_div_cnt;
    logic [DivW-1:0] w_div_cnt_d;
    logic            r_tick;

    always_comb begin
        w_div_cnt_d = (r_div_cnt == DivLast) ? '0 : r_div_cnt + DivW'(1);
    end

    // r_tick is registered from the next count so it is high exactly while
    // r_div_cnt == TICK_DIV-1, yet still reads 0 straight out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_cnt_d;
            r_tick    <= (w_div_cnt_d == DivLast);
        end
    end

    assign o_tick = r_tick;

    // ---------------- Debounce cells ----------------
    logic [NUM_KEYS-1:0] w_key_db;
    logic [NUM_SW-1:0]   w_sw_db;
`ifdef DE2_KEY_PRESS_PULSE_EN
    logic [NUM_KEYS-1:0] w_key_fall;
    logic [NUM_SW-1:0]   w_sw_fall;
`endif

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_VAL    (1'b1)
        ) u_cell (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_tick    (r_tick),
            .i_raw     (i_key_raw[i]),
            .o_db      (w_key_db[i])
`ifdef DE2_KEY_PRESS_PULSE_EN
            ,
            .o_fall    (w_key_fall[i])
`endif
        );
    end

    for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_VAL    (1'b0)
        ) u_cell (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_tick    (r_tick),
            .i_raw     (i_sw_raw[j]),
            .o_db      (w_sw_db[j])
`ifdef DE2_KEY_PRESS_PULSE_EN
            ,
            .o_fall    (w_sw_fall[j])
`endif
        );
    end

    assign o_key_db = w_key_db;
    assign o_sw_db  = w_sw_db;

`ifdef DE2_KEY_PRESS_PULSE_EN
    assign o_key_press = w_key_fall;
`endif

    // ---------------- Reset conditioner ----------------
    rst_state_t       r_state;
    rst_state_t       w_state_d;
    logic [HoldW-1:0] r_hold_cnt;
    logic [HoldW-1:0] w_hold_cnt_d;
    logic             r_sys_reset_n;

    always_comb begin
        w_state_d    = r_state;
        w_hold_cnt_d = r_hold_cnt;
        case (r_state)
            HOLD: begin
                if (!w_key_db[0]) begin
                    w_hold_cnt_d = '0;
                end else if (r_tick) begin
                    if (r_hold_cnt == HoldLast) begin
                        w_state_d    = RUN;
                        w_hold_cnt_d = '0;
                    end else begin
                        w_hold_cnt_d = r_hold_cnt + HoldW'(1);
                    end
                end
            end
            RUN: begin
                if (!w_key_db[0]) begin
                    w_state_d    = HOLD;
                    w_hold_cnt_d = '0;
                end
            end
            default: begin
                w_state_d    = HOLD;
                w_hold_cnt_d = '0;
            end
        endcase
    end

    // Decoding the next state keeps the output in step with the state
    // register while still coming straight from a flop.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= HOLD;
            r_hold_cnt    <= '0;
            r_sys_reset_n <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_hold_cnt    <= w_hold_cnt_d;
            r_sys_reset_n <= (w_state_d == RUN);
        end
    end

    assign o_sys_reset_n = r_sys_reset_n;

endmodule

// File: tb/tb_de2_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_de2_input_conditioner
// Directed bench for de2_input_conditioner with TICK_DIV=4, STABLE_TICKS=3,
// RST_HOLD_TICKS=2. A cycle-indexed reference model derives every output from
// tick arithmetic (ticks in a window of cycles) and is compared on each
// falling edge; directed sections add hand-computed latencies.
// Cycle 0 is the cycle right after the last reset edge.
// ---------------------------------------------------------------------------
module tb_de2_input_conditioner;

    localparam int NK = 4;
    localparam int NS = 18;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RH = 2;

    logic          clk;
    logic          reset_n;
    logic [NK-1:0] key_raw;
    logic [NS-1:0] sw_raw;
    logic [NK-1:0] key_db;
    logic [NS-1:0] sw_db;
    logic          sys_reset_n;
    logic          tick;
`ifdef DE2_KEY_PRESS_PULSE_EN
    logic [NK-1:0] key_press;
`endif

    de2_input_conditioner #(
        .TICK_DIV       (TD),
        .STABLE_TICKS   (ST),
        .RST_HOLD_TICKS (RH),
        .NUM_KEYS       (NK),
        .NUM_SW         (NS)
    ) u_dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_key_raw     (key_raw),
        .i_sw_raw      (sw_raw),
        .o_key_db      (key_db),
        .o_sw_db       (sw_db),
        .o_sys_reset_n (sys_reset_n),
        .o_tick        (tick)
`ifdef DE2_KEY_PRESS_PULSE_EN
        ,
        .o_key_press   (key_press)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Number of tick cycles in cycles a..b inclusive (tick when n % TD == TD-1).
    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TD - a / TD;
    endfunction

    // ---------------- Reference model ----------------
    bit            chk_en = 1'b0;
    int            m_cyc;
    logic [NK-1:0] m_k1, m_k2, m_kdb;
    logic [NS-1:0] m_s1, m_s2, m_sdb;
    int            k_ms[NK];   // first cycle of current mismatch run, -1 = none
    int            s_ms[NS];
    int            m_rel;      // first cycle of current key_db[0]==1 run, -1 = none
    bit            m_sys;
`ifdef DE2_KEY_PRESS_PULSE_EN
    logic [NK-1:0] m_press;
`endif

    always @(posedge clk) begin
        int c;
        if (!reset_n) begin
            chk_en = 1'b1;
            m_cyc  = 0;
            m_k1   = '1;
            m_k2   = '1;
            m_kdb  = '1;
            m_s1   = '0;
            m_s2   = '0;
            m_sdb  = '0;
            foreach (k_ms[i]) k_ms[i] = -1;
            foreach (s_ms[i]) s_ms[i] = -1;
            m_rel  = 0;
            m_sys  = 1'b0;
`ifdef DE2_KEY_PRESS_PULSE_EN
            m_press = '0;
`endif
        end else begin
            c = m_cyc;
            // Reset conditioner sees the pre-edge debounced KEY[0].
            if (!m_kdb[0]) begin
                m_rel = -1;
            end else if (m_rel < 0) begin
                m_rel = c;
            end
            m_sys = (m_rel >= 0) && (ticks_in(m_rel, c) >= RH);
`ifdef DE2_KEY_PRESS_PULSE_EN
            m_press = '0;
`endif
            for (int i = 0; i < NK; i++) begin
                if (m_k2[i] == m_kdb[i]) begin
                    k_ms[i] = -1;
                end else begin
                    if (k_ms[i] < 0) k_ms[i] = c;
                    if (ticks_in(k_ms[i], c) >= ST) begin
`ifdef DE2_KEY_PRESS_PULSE_EN
                        if (m_kdb[i]) m_press[i] = 1'b1;
`endif
                        m_kdb[i] = m_k2[i];
                        k_ms[i]  = -1;
                    end
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (m_s2[i] == m_sdb[i]) begin
                    s_ms[i] = -1;
                end else begin
                    if (s_ms[i] < 0) s_ms[i] = c;
                    if (ticks_in(s_ms[i], c) >= ST) begin
                        m_sdb[i] = m_s2[i];
                        s_ms[i]  = -1;
                    end
                end
            end
            m_k2  = m_k1;
            m_k1  = key_raw;
            m_s2  = m_s1;
            m_s1  = sw_raw;
            m_cyc = c + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tick", 32'(tick), 32'((m_cyc % TD) == (TD - 1)));
            check("key_db", 32'(key_db), 32'(m_kdb));
            check("sw_db", 32'(sw_db), 32'(m_sdb));
            check("sys_reset_n", 32'(sys_reset_n), 32'(m_sys));
`ifdef DE2_KEY_PRESS_PULSE_EN
            check("key_press", 32'(key_press), 32'(m_press));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- Directed stimulus ----------------
    int t1, s1, d, nt, bad, f, target, np;
    bit rose;

    initial begin
        reset_n = 1'b0;
        key_raw = '1;
        sw_raw  = '0;

        // 1. Reset and start-up: ticks in cycles 3 and 7, RUN from cycle 8.
        @(posedge clk); #2;
        @(negedge clk);
        check("rst_key_db", 32'(key_db), 32'hF);
        check("rst_sw_db", 32'(sw_db), 32'h0);
        check("rst_sys_reset_n", 32'(sys_reset_n), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        t1 = -1;
        s1 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tick && t1 < 0) t1 = k;
            if (sys_reset_n && s1 < 0) s1 = k;
        end
        check("first_tick_cycle", t1, 3);
        check("first_run_cycle", s1, 8);

        // 2. Clean switch edge: 3 ticks after the synchronised change.
        @(posedge clk); #2;
        sw_raw[5] = 1'b1;
        d  = -1;
        nt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (d < 0) begin
                if (sw_db[5]) d = k;
                else if (k >= 2 && tick) nt++;
            end
        end
        check_range("sw5_latency", d, 11, 14);
        check("sw5_tick_count", nt, 3);

        // 3. Bounce every 5 cycles never commits, then a steady level does.
        bad = 0;
        for (int seg = 0; seg < 12; seg++) begin
            @(posedge clk); #2;
            sw_raw[3] = (seg % 2 == 0);
            repeat (5) begin
                @(negedge clk);
                if (sw_db[3]) bad++;
            end
        end
        check("sw3_bounce_held_low", bad, 0);
        @(posedge clk); #2;
        sw_raw[3] = 1'b1;
        d = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sw_db[3] && d < 0) d = k;
        end
        check_range("sw3_steady_latency", d, 11, 14);

        // 4. KEY[0] press drops the reset next cycle; release re-arms it.
        @(posedge clk); #2;
        key_raw[0] = 1'b0;
        f = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (f >= 0 && k == f + 1) check("key0_sys_low_next", 32'(sys_reset_n), 32'h0);
            if (!key_db[0] && f < 0) begin
                f = k;
                check("key0_sys_high_at_fall", 32'(sys_reset_n), 32'h1);
            end
        end
        check_range("key0_fall_latency", f, 11, 14);
        @(posedge clk); #2;
        key_raw[0] = 1'b1;
        rose   = 1'b0;
        nt     = 0;
        target = -1;
        bad    = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (target >= 0 && k == target + 1) check("key0_run_after_2nd_tick",
                                                      32'(sys_reset_n), 32'h1);
            else if (target < 0 && sys_reset_n) bad++;
            if (key_db[0]) rose = 1'b1;
            if (rose && tick && target < 0) begin
                nt++;
                if (nt == 2) target = k;
            end
        end
        check("key0_no_early_run", bad, 0);
        check_range("key0_second_tick_seen", target, 11, 22);

        // 5. One-cycle reset in the middle of a partial sw_raw[0] count.
        @(posedge clk); #2;
        sw_raw[0] = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("sw0_not_committed_yet", 32'(sw_db[0]), 32'h0);
        reset_n = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        d = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) check("midrst_sw_db_cleared", 32'(sw_db), 32'h0);
            if (sw_db[0] && d < 0) d = k;
        end
        check("midrst_sw0_cycle", d, 12);

`ifdef DE2_KEY_PRESS_PULSE_EN
        // 6. key_raw[2] press gives one pulse on the 1->0 edge only.
        np = 0;
        @(posedge clk); #2;
        key_raw[2] = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                @(posedge clk); #2;
                key_raw[2] = 1'b1;
            end
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (key_press != '0) begin
                    np++;
                    check("press_only_bit2", 32'(key_press), 32'h4);
                    check("press_with_db_low", 32'(key_db[2]), 32'h0);
                end
            end
        end
        check("press_pulse_count", np, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
